// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier ciphertext datapath.
// Contents:
//   REGISTER_SIZE  - word width in bits
//   BITS_IN_NUM    - ciphertext width in bits
//   WORDS_PER_CT   - words per ciphertext
//   rx_state_e     - SPI receiver FSM states
package paillier_pkg;

  localparam int unsigned REGISTER_SIZE = 32;
  localparam int unsigned BITS_IN_NUM   = 4096;
  localparam int unsigned WORDS_PER_CT  = BITS_IN_NUM / REGISTER_SIZE;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_EMIT  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ciphertext_spi_receiver_sync.sv
// input_synchronizer: multi-flop synchronizer for one asynchronous input.
// Parameters:
//   STAGES      - number of flops in the chain (>= 1)
//   RESET_VALUE - value loaded into every flop during reset
// Ports:
//   clk_i - system clock
//   rst_i - synchronous active-high reset
//   d_i   - asynchronous input
//   q_o   - synchronized output
module input_synchronizer #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift-left form keeps STAGES == 1 legal (no negative slice bounds).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
    end
  end

  always_comb q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ciphertext_spi_receiver.sv
// ciphertext_spi_receiver: SPI peripheral that assembles REGISTER_SIZE-bit
// words (MSB first) from an upstream SPI controller and tags each with its
// position inside a BITS_IN_NUM-bit ciphertext.
// Optional build macro: CT_RX_TIMEOUT_EN - abandons a partial ciphertext
// after TIMEOUT_CYCLES idle clocks between words.
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous active-high reset
//   copi_in         - SPI serial data
//   dclk_in         - SPI clock, idle low
//   cs_in           - SPI chip select, active low
//   data_out        - received word (zero when not valid)
//   data_valid_out  - one-cycle pulse qualifying data_out
//   word_index_out  - index of the word within the ciphertext (0 = LSW)
//   last_word_out   - high with data_valid_out on the final word
//   frame_error_out - one-cycle pulse on a dropped word or aborted ciphertext
module ciphertext_spi_receiver #(
  parameter int unsigned REGISTER_SIZE  = paillier_pkg::REGISTER_SIZE,
  parameter int unsigned BITS_IN_NUM    = paillier_pkg::BITS_IN_NUM,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                                           clk_in,
  input  logic                                           rst_in,
  input  logic                                           copi_in,
  input  logic                                           dclk_in,
  input  logic                                           cs_in,
  output logic [REGISTER_SIZE-1:0]                       data_out,
  output logic                                           data_valid_out,
  output logic [$clog2(BITS_IN_NUM/REGISTER_SIZE)-1:0]   word_index_out,
  output logic                                           last_word_out,
  output logic                                           frame_error_out
);

  import paillier_pkg::*;

  localparam int unsigned WORDS_PER_CT = BITS_IN_NUM / REGISTER_SIZE;
  localparam int unsigned IDX_W        = $clog2(WORDS_PER_CT);
  localparam int unsigned CNT_W        = $clog2(REGISTER_SIZE + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REGISTER_SIZE);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(REGISTER_SIZE + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_CT - 1);

  if (REGISTER_SIZE < 2 || WORDS_PER_CT < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("ciphertext_spi_receiver: unsupported parameter combination");
  end

  // ---------------------------------------------------------------------
  // Input synchronizers (reset to the idle bus state)
  // ---------------------------------------------------------------------
  logic copi_s, dclk_s, cs_s;

  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_copi (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (copi_in),
    .q_o   (copi_s)
  );

  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_dclk (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (dclk_in),
    .q_o   (dclk_s)
  );

  input_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .d_i   (cs_in),
    .q_o   (cs_s)
  );

  // ---------------------------------------------------------------------
  // Edge detection on synchronized signals
  // ---------------------------------------------------------------------
  logic cs_prev_q, dclk_prev_q;
  logic cs_fall, cs_rise, dclk_rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cs_prev_q   <= 1'b1;
      dclk_prev_q <= 1'b0;
    end else begin
      cs_prev_q   <= cs_s;
      dclk_prev_q <= dclk_s;
    end
  end

  always_comb begin
    cs_fall   = cs_prev_q & ~cs_s;
    cs_rise   = ~cs_prev_q & cs_s;
    dclk_rise = ~dclk_prev_q & dclk_s;
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  rx_state_e                state_q, state_d;
  logic [REGISTER_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q,   cnt_d;
  logic [IDX_W-1:0]         idx_q,   idx_d;
  logic                     word_ok;
  logic                     timeout_hit;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= RX_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (cs_fall) state_d = RX_SHIFT;
      RX_SHIFT: if (cs_rise) state_d = RX_EMIT;
      RX_EMIT:  state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb word_ok = (cnt_q == CNT_FULL);

  // Datapath next-state: shift register, saturating bit counter, word index
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      RX_IDLE: begin
        if (cs_fall) cnt_d = '0;
      end
      RX_SHIFT: begin
        if (dclk_rise && !cs_s) begin
          shift_d = {shift_q[REGISTER_SIZE-2:0], copi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end
      RX_EMIT: begin
        if (word_ok) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
    if (timeout_hit) idx_d = '0;
  end

  // ---------------------------------------------------------------------
  // Inter-word timeout (optional)
  // ---------------------------------------------------------------------
`ifdef CT_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a partial ciphertext.
  always_comb timeout_hit = (state_q == RX_IDLE) && (idx_q != '0) && (to_q == TO_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in || state_q != RX_IDLE || idx_q == '0 || timeout_hit) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + 1'b1;
    end
  end
`else
  always_comb timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    data_valid_out  = 1'b0;
    frame_error_out = timeout_hit;
    if (state_q == RX_EMIT) begin
      data_valid_out  = word_ok;
      frame_error_out = frame_error_out | ~word_ok;
    end
    data_out       = data_valid_out ? shift_q : '0;
    word_index_out = idx_q;
    last_word_out  = data_valid_out && (idx_q == IDX_LAST);
  end

endmodule

// File: tb/tb_ciphertext_spi_receiver.sv
// Self-checking bench for ciphertext_spi_receiver. Expected words are queued
// when driven and popped when data_valid_out fires. Define CT_RX_TIMEOUT_EN
// to also exercise the inter-word timeout with TIMEOUT_CYCLES = 1000.
module tb_ciphertext_spi_receiver;

  localparam int unsigned RS    = 32;
  localparam int unsigned NW    = 128;
  localparam int unsigned TO    = 1000;
  localparam int unsigned PHASE = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        copi_in = 1'b0;
  logic        dclk_in = 1'b0;
  logic        cs_in = 1'b1;
  logic [31:0] data_out;
  logic        data_valid_out;
  logic [6:0]  word_index_out;
  logic        last_word_out;
  logic        frame_error_out;

  always #5 clk_in = ~clk_in;

`ifdef CT_RX_TIMEOUT_EN
  ciphertext_spi_receiver #(
    .REGISTER_SIZE  (32),
    .BITS_IN_NUM    (4096),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
`else
  ciphertext_spi_receiver #(
    .REGISTER_SIZE  (32),
    .BITS_IN_NUM    (4096),
    .SYNC_STAGES    (2)
  ) dut (
`endif
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .copi_in         (copi_in),
    .dclk_in         (dclk_in),
    .cs_in           (cs_in),
    .data_out        (data_out),
    .data_valid_out  (data_valid_out),
    .word_index_out  (word_index_out),
    .last_word_out   (last_word_out),
    .frame_error_out (frame_error_out)
  );

  typedef struct {
    logic [31:0] data;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  int          words_seen = 0;
  logic [6:0]  exp_idx = '0;
  logic        prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (data_valid_out) begin
        words_seen++;
        check_eq("valid_one_cycle", 64'(prev_valid), 64'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_word", 64'(data_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("data", 64'(data_out), 64'(e.data));
          check_eq("index", 64'(word_index_out), 64'(e.idx));
          check_eq("last", 64'(last_word_out), 64'(e.last));
        end
      end else if (last_word_out) begin
        check_eq("last_without_valid", 64'(last_word_out), 64'd0);
      end
      if (frame_error_out) err_seen++;
    end
    prev_valid = data_valid_out;
  end

  task automatic clock_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi_in = v[i];
      tick(PHASE);
      dclk_in = 1'b1;
      tick(PHASE);
      dclk_in = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    cs_in = 1'b0;
    tick(4);
    clock_bits(v, n);
    tick(3);
    cs_in = 1'b1;
    tick(10);
  endtask

  task automatic send_word(input logic [31:0] v);
    exp_t e;
    e.data = v;
    e.idx  = exp_idx;
    e.last = (exp_idx == 7'(NW - 1));
    sb.push_back(e);
    exp_idx = exp_idx + 1'b1;
    send_bits(64'(v), RS);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(3);
    check_eq("rst_data", 64'(data_out), 64'd0);
    check_eq("rst_valid", 64'(data_valid_out), 64'd0);
    check_eq("rst_last", 64'(last_word_out), 64'd0);
    check_eq("rst_error", 64'(frame_error_out), 64'd0);
    check_eq("rst_index", 64'(word_index_out), 64'd0);
    cs_in   = 1'b1;
    dclk_in = 1'b0;
    copi_in = 1'b0;
    tick(3);
    rst_in = 1'b0;
    sb.delete();
    exp_idx = '0;
    tick(5);
  endtask

  initial begin
    int w0;

    do_reset();

    // Single word
    send_word(32'hDEAD_BEEF);
    drain("drain_single");
    check_eq("err_single", 64'(err_seen), 64'(exp_err));

    // Full ciphertext plus the wrap to index 0
    do_reset();
    w0 = words_seen;
    for (int v = 0; v < NW; v++) send_word(32'(v));
    send_word(32'hA5A5_0001);
    drain("drain_ct");
    check_eq("ct_word_count", 64'(words_seen - w0), 64'(NW + 1));
    check_eq("err_ct", 64'(err_seen), 64'(exp_err));

    // Short word: dropped, flagged, index unchanged
    send_bits(64'h000A_BCDE, 20);
    exp_err++;
    check_eq("err_short", 64'(err_seen), 64'(exp_err));
    send_word(32'h1234_5678);
    drain("drain_short");

    // Over-long word (33 bits)
    send_bits(64'h1_CAFE_F00D, 33);
    exp_err++;
    check_eq("err_long", 64'(err_seen), 64'(exp_err));
    send_word(32'h8765_4321);
    drain("drain_long");

`ifdef CT_RX_TIMEOUT_EN
    do_reset();
    for (int v = 0; v < 5; v++) send_word(32'h100 + 32'(v));
    drain("drain_to");
    check_eq("err_before_to", 64'(err_seen), 64'(exp_err));
    tick(TO + 100);
    exp_err++;
    check_eq("err_timeout", 64'(err_seen), 64'(exp_err));
    exp_idx = '0;
    send_word(32'h0BAD_F00D);
    drain("drain_after_to");
`endif

    // Reset in the middle of a word
    cs_in = 1'b0;
    tick(4);
    clock_bits(64'h3FF, 10);
    do_reset();
    send_word(32'h0000_0001);
    drain("drain_mid_rst");
    check_eq("err_final", 64'(err_seen), 64'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
